// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared definitions for the AXI4-Lite single-command master:
// FSM state encodings, response codes and the timeout limit.
package axi_lite_cmd_master_pkg;

  localparam int unsigned STATE_W = 3;

  // FSM state encodings
  localparam logic [STATE_W-1:0] IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] WR_AW_W = 3'd1;
  localparam logic [STATE_W-1:0] WR_B    = 3'd2;
  localparam logic [STATE_W-1:0] RD_AR   = 3'd3;
  localparam logic [STATE_W-1:0] RD_R    = 3'd4;
  localparam logic [STATE_W-1:0] DONE    = 3'd5;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Code reported locally when the slave never answers
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  // Cycles a transaction may stay outstanding before it is abandoned
  localparam int unsigned TIMEOUT_CYCLES = 256;
  localparam int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

endpackage : axi_lite_cmd_master_pkg

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master that turns one local command into one AXI read or write
// and returns a single-cycle completion pulse. Only one transaction is ever
// outstanding. All outputs are registered; valids never depend on readies
// combinationally.
// Optional feature: define AXI_LITE_CMD_MASTER_TIMEOUT_EN to abandon a
// transaction after TIMEOUT_CYCLES and report rsp_resp = 2'b11.
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int unsigned C_M00_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_M00_AXI_DATA_WIDTH = 32
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_areset,
  // local command side
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] cmd_wdata,
  // local response side
  output logic                            rsp_valid,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                      rsp_resp,
  // AXI write address
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_awaddr,
  output logic                            m00_axi_awvalid,
  input  logic                            m00_axi_awready,
  // AXI write data
  output logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_wdata,
  output logic                            m00_axi_wvalid,
  input  logic                            m00_axi_wready,
  // AXI write response
  input  logic [1:0]                      m00_axi_bresp,
  input  logic                            m00_axi_bvalid,
  output logic                            m00_axi_bready,
  // AXI read address
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  // AXI read data
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready
);

  localparam int unsigned AW = C_M00_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M00_AXI_DATA_WIDTH;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;

  logic          cmd_ready_nxt;
  logic          rsp_valid_nxt;
  logic [DW-1:0] rsp_rdata_nxt;
  logic [1:0]    rsp_resp_nxt;
  logic [AW-1:0] awaddr_nxt;
  logic          awvalid_nxt;
  logic [DW-1:0] wdata_nxt;
  logic          wvalid_nxt;
  logic          bready_nxt;
  logic [AW-1:0] araddr_nxt;
  logic          arvalid_nxt;
  logic          rready_nxt;

  logic          accept;
  logic [AW-1:0] addr_aligned;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_cnt_nxt;
  logic             in_flight;
`endif

  assign accept       = cmd_valid && cmd_ready;
  assign addr_aligned = cmd_addr & ~AW'(3);

  // Next-state and next-output computation for every registered output
  always_comb begin
    state_nxt     = state;
    cmd_ready_nxt = cmd_ready;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_resp_nxt  = rsp_resp;
    awaddr_nxt    = m00_axi_awaddr;
    awvalid_nxt   = m00_axi_awvalid;
    wdata_nxt     = m00_axi_wdata;
    wvalid_nxt    = m00_axi_wvalid;
    bready_nxt    = m00_axi_bready;
    araddr_nxt    = m00_axi_araddr;
    arvalid_nxt   = m00_axi_arvalid;
    rready_nxt    = m00_axi_rready;

    case (state)
      IDLE: begin
        if (accept) begin
          cmd_ready_nxt = 1'b0;
          if (cmd_write) begin
            awaddr_nxt  = addr_aligned;
            wdata_nxt   = cmd_wdata;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_AW_W;
          end else begin
            araddr_nxt  = addr_aligned;
            arvalid_nxt = 1'b1;
            state_nxt   = RD_AR;
          end
        end
      end

      WR_AW_W: begin
        // AW and W retire independently; move on once both are gone
        if (m00_axi_awvalid && m00_axi_awready) begin
          awvalid_nxt = 1'b0;
        end
        if (m00_axi_wvalid && m00_axi_wready) begin
          wvalid_nxt = 1'b0;
        end
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_B;
        end
      end

      WR_B: begin
        if (m00_axi_bvalid && m00_axi_bready) begin
          bready_nxt    = 1'b0;
          rsp_resp_nxt  = m00_axi_bresp;
          rsp_rdata_nxt = '0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end

      RD_AR: begin
        if (m00_axi_arvalid && m00_axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_R;
        end
      end

      RD_R: begin
        if (m00_axi_rvalid && m00_axi_rready) begin
          rready_nxt    = 1'b0;
          rsp_resp_nxt  = m00_axi_rresp;
          rsp_rdata_nxt = m00_axi_rdata;
          rsp_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end

      DONE: begin
        cmd_ready_nxt = 1'b1;
        state_nxt     = IDLE;
      end

      default: begin
        cmd_ready_nxt = 1'b1;
        awvalid_nxt   = 1'b0;
        wvalid_nxt    = 1'b0;
        bready_nxt    = 1'b0;
        arvalid_nxt   = 1'b0;
        rready_nxt    = 1'b0;
        state_nxt     = IDLE;
      end
    endcase

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    in_flight   = (state != IDLE) && (state != DONE);
    tmo_cnt_nxt = tmo_cnt;
    if (state == IDLE && accept) begin
      tmo_cnt_nxt = '0;
    end else if (in_flight) begin
      tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
    end

    // A real response landing on the same edge takes priority over the abort
    if (in_flight && (tmo_cnt_nxt == TMO_W'(TIMEOUT_CYCLES)) && (state_nxt != DONE)) begin
      awvalid_nxt   = 1'b0;
      wvalid_nxt    = 1'b0;
      bready_nxt    = 1'b0;
      arvalid_nxt   = 1'b0;
      rready_nxt    = 1'b0;
      rsp_resp_nxt  = RESP_TIMEOUT;
      rsp_rdata_nxt = '0;
      rsp_valid_nxt = 1'b1;
      state_nxt     = DONE;
    end
`endif
  end

  // State and output registers with synchronous reset
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state           <= IDLE;
      cmd_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_resp        <= RESP_OKAY;
      m00_axi_awaddr  <= '0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wdata   <= '0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_bready  <= 1'b0;
      m00_axi_araddr  <= '0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_rready  <= 1'b0;
    end else begin
      state           <= state_nxt;
      cmd_ready       <= cmd_ready_nxt;
      rsp_valid       <= rsp_valid_nxt;
      rsp_rdata       <= rsp_rdata_nxt;
      rsp_resp        <= rsp_resp_nxt;
      m00_axi_awaddr  <= awaddr_nxt;
      m00_axi_awvalid <= awvalid_nxt;
      m00_axi_wdata   <= wdata_nxt;
      m00_axi_wvalid  <= wvalid_nxt;
      m00_axi_bready  <= bready_nxt;
      m00_axi_araddr  <= araddr_nxt;
      m00_axi_arvalid <= arvalid_nxt;
      m00_axi_rready  <= rready_nxt;
    end
  end

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  // Outstanding-transaction age counter
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
    end
  end
`endif

endmodule : axi_lite_cmd_master
